// File: rtl/demux_sched_if.sv
// Producer/consumer bundle for the demux scheduler: serial valid/ready input,
// per-destination enable/ready, and the registered 1-to-4 routing outputs.
interface demux_sched_if #(
    parameter int CNT_W = 3
);
    logic             din_valid;
    logic             din;
    logic             din_ready;
    logic [3:0]       dst_en;
    logic [3:0]       dst_ready;
    logic [1:0]       sel;
    logic             dout0;
    logic             dout1;
    logic             dout2;
    logic             dout3;
    logic [3:0]       dvalid;
    logic             busy;
    logic [CNT_W-1:0] beat_cnt;

    modport slave (
        input  din_valid, din, dst_en, dst_ready,
        output din_ready, sel, dout0, dout1, dout2, dout3, dvalid, busy, beat_cnt
    );

    modport master (
        output din_valid, din, dst_en, dst_ready,
        input  din_ready, sel, dout0, dout1, dout2, dout3, dvalid, busy, beat_cnt
    );
endinterface

// File: rtl/demux_sched.sv
// Round-robin burst scheduler: routes a 1-bit valid/ready stream to one of four
// enabled consumers at a time, BURST_LEN beats per grant, registered outputs.
module demux_sched #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 3
) (
    input  logic          clk,
    input  logic          rst,
    demux_sched_if.slave  bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [3:0]       dout_q, dout_d;
    logic [3:0]       dvalid_q, dvalid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic             found;
    logic [1:0]       found_idx;
    logic             sel_en;
    logic             din_ready;
    logic             xfer;
    logic [3:0]       sel_oh;

    // First enabled destination at or after ptr, wrapping 3 -> 0.
    always_comb begin
        found     = 1'b0;
        found_idx = ptr_q;
        for (int i = 0; i < 4; i++) begin
            if (!found && bus.dst_en[ptr_q + 2'(i)]) begin
                found     = 1'b1;
                found_idx = ptr_q + 2'(i);
            end
        end
    end

    assign sel_en    = bus.dst_en[sel_q];
    assign din_ready = (state_q == BURST) && bus.dst_ready[sel_q] && sel_en;
    assign xfer      = din_ready && bus.din_valid;
    assign sel_oh    = 4'b0001 << sel_q;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        dout_d   = 4'b0000;
        dvalid_d = 4'b0000;
        case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d   = found_idx;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = BURST;
                end
            end
            BURST: begin
                // Losing the enable ends the grant; din_ready is already low here.
                if (!sel_en) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    ptr_d   = sel_q + 2'd1;
                end else if (xfer) begin
                    dvalid_d = sel_oh;
                    dout_d   = {4{bus.din}} & sel_oh;
                    if (cnt_q == LAST) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                        ptr_d   = sel_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= 2'd0;
            ptr_q    <= 2'd0;
            dout_q   <= 4'b0000;
            dvalid_q <= 4'b0000;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.din_ready = din_ready;
    assign bus.sel       = sel_q;
    assign bus.dout0     = dout_q[0];
    assign bus.dout1     = dout_q[1];
    assign bus.dout2     = dout_q[2];
    assign bus.dout3     = dout_q[3];
    assign bus.dvalid    = dvalid_q;
    assign bus.busy      = busy_q;
    assign bus.beat_cnt  = cnt_q;
endmodule

// File: tb/tb_demux_sched.sv
// Bench for demux_sched: reference model feeds a beat scoreboard, each test task
// checks its scenario inline.
module tb_demux_sched;
    localparam int BL = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    demux_sched_if #(.CNT_W(CW)) bif ();
    demux_sched #(.BURST_LEN(BL), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bif));

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    logic [3:0] dv_hist[$];
    logic [1:0] grant_q[$];
    logic       prev_busy;
    int         rdy_bad;

    logic       m_busy;
    logic [1:0] m_sel;
    logic [1:0] m_ptr;
    int         m_cnt;

    task automatic model_clear();
        m_busy = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
        prev_busy = 0; rdy_bad = 0;
        exp_q.delete(); obs_q.delete(); dv_hist.delete(); grant_q.delete();
    endtask

    // One clock: model the accepting edge, then sample registered outputs.
    task automatic step();
        logic       m_rdy;
        logic       xfer;
        logic [3:0] oh;
        logic [1:0] idx;
        bit         fnd;
        #1;
        m_rdy = m_busy && bif.dst_ready[m_sel] && bif.dst_en[m_sel];
        if (bif.din_ready !== m_rdy) rdy_bad++;
        xfer = m_rdy && bif.din_valid;
        oh   = 4'b0001 << m_sel;
        if (!m_busy) begin
            fnd = 0;
            for (int i = 0; i < 4; i++) begin
                idx = m_ptr + 2'(i);
                if (!fnd && bif.dst_en[idx]) begin fnd = 1; m_sel = idx; end
            end
            if (fnd) begin m_busy = 1; m_cnt = 0; end
        end else if (!bif.dst_en[m_sel]) begin
            m_busy = 0; m_cnt = 0; m_ptr = m_sel + 2'd1;
        end else if (xfer) begin
            exp_q.push_back({oh, bif.din ? oh : 4'b0000});
            if (m_cnt == BL - 1) begin m_busy = 0; m_cnt = 0; m_ptr = m_sel + 2'd1; end
            else m_cnt++;
        end
        @(posedge clk);
        #1;
        dv_hist.push_back(bif.dvalid);
        if (bif.dvalid != 4'b0000)
            obs_q.push_back({bif.dvalid, bif.dout3, bif.dout2, bif.dout1, bif.dout0});
        if (!prev_busy && bif.busy) grant_q.push_back(bif.sel);
        prev_busy = bif.busy;
        bif.din = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        bif.din_valid = 0; bif.din = 0; bif.dst_en = 4'b1111; bif.dst_ready = 4'b1111;
        #1 rst = 1'b1;
        #1;
        total_cnt++; if (bif.sel !== 2'd0) $display("FAIL rst_sel: got %0d want 0", bif.sel); else pass_cnt++;
        total_cnt++; if (bif.dvalid !== 4'b0) $display("FAIL rst_dvalid: got %b want 0000", bif.dvalid); else pass_cnt++;
        total_cnt++; if (bif.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bif.busy); else pass_cnt++;
        total_cnt++; if (bif.beat_cnt !== 3'd0) $display("FAIL rst_cnt: got %0d want 0", bif.beat_cnt); else pass_cnt++;
        total_cnt++; if ({bif.dout3, bif.dout2, bif.dout1, bif.dout0} !== 4'b0)
            $display("FAIL rst_dout: got %b want 0000", {bif.dout3, bif.dout2, bif.dout1, bif.dout0}); else pass_cnt++;
        total_cnt++; if (bif.din_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", bif.din_ready); else pass_cnt++;
        #1 rst = 1'b0;
    endtask

    task automatic test_rotation();
        int bad, n;
        logic [3:0] want;
        logic [1:0] gexp [5];
        gexp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        bif.dst_en = 4'b1111; bif.dst_ready = 4'b1111; bif.din_valid = 1;
        for (int i = 0; i < 21; i++) step();
        bad = 0;
        for (int i = 0; i < 21; i++) begin
            want = (i % 5 == 0) ? 4'b0000 : (4'b0001 << ((i / 5) % 4));
            if (dv_hist[i] !== want) bad++;
        end
        total_cnt++; if (bad != 0) $display("FAIL rot_cadence: %0d cycles wrong dvalid, want 0", bad); else pass_cnt++;
        total_cnt++; if (grant_q.size() != 5) $display("FAIL rot_grants: got %0d grants want 5", grant_q.size());
        else begin
            bad = 0;
            for (int i = 0; i < 5; i++) if (grant_q[i] !== gexp[i]) bad++;
            if (bad != 0) $display("FAIL rot_order: %0d grants out of order (want 0,1,2,3,0)", bad); else pass_cnt++;
        end
        bad = 0; n = obs_q.size();
        while (exp_q.size() > 0 && obs_q.size() > 0) if (exp_q.pop_front() !== obs_q.pop_front()) bad++;
        total_cnt++; if (bad != 0 || exp_q.size() != 0 || obs_q.size() != 0 || n != 16)
            $display("FAIL rot_data: bad=%0d beats=%0d want 16 leftover=%0d/%0d", bad, n, exp_q.size(), obs_q.size());
        else pass_cnt++;
        total_cnt++; if (rdy_bad != 0) $display("FAIL rot_ready: %0d cycles wrong din_ready, want 0", rdy_bad); else pass_cnt++;
    endtask

    task automatic test_sparse();
        int bad, n;
        logic [1:0] gexp [4];
        gexp = '{2'd1, 2'd3, 2'd1, 2'd3};
        do_reset();
        bif.dst_en = 4'b1010; bif.dst_ready = 4'b1111; bif.din_valid = 1;
        for (int i = 0; i < 20; i++) step();
        bad = 0;
        foreach (dv_hist[i]) if (dv_hist[i][0] || dv_hist[i][2]) bad++;
        total_cnt++; if (bad != 0) $display("FAIL sparse_strobe: %0d strobes to dst 0/2, want 0", bad); else pass_cnt++;
        bad = (grant_q.size() != 4) ? 1 : 0;
        if (bad == 0) for (int i = 0; i < 4; i++) if (grant_q[i] !== gexp[i]) bad++;
        total_cnt++; if (bad != 0) $display("FAIL sparse_order: %0d grants got wrong (count %0d) want 1,3,1,3", bad, grant_q.size()); else pass_cnt++;
        bad = 0; n = obs_q.size();
        while (exp_q.size() > 0 && obs_q.size() > 0) if (exp_q.pop_front() !== obs_q.pop_front()) bad++;
        total_cnt++; if (bad != 0 || exp_q.size() != 0 || obs_q.size() != 0 || n != 16)
            $display("FAIL sparse_data: bad=%0d beats=%0d want 16", bad, n);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int bad, n, cnt2;
        do_reset();
        bif.dst_en = 4'b1111; bif.dst_ready = 4'b1111; bif.din_valid = 1;
        for (int i = 0; i < 12; i++) step();
        bif.dst_ready = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            #1;
            total_cnt++; if (bif.din_ready !== 1'b0) $display("FAIL bp_ready%0d: got %b want 0", k, bif.din_ready); else pass_cnt++;
            step();
            total_cnt++; if (bif.beat_cnt !== 3'd1 || bif.dvalid !== 4'b0)
                $display("FAIL bp_hold%0d: cnt=%0d dvalid=%b want 1/0000", k, bif.beat_cnt, bif.dvalid); else pass_cnt++;
        end
        bif.dst_ready = 4'b1111;
        for (int i = 0; i < 3; i++) step();
        total_cnt++; if (bif.busy !== 1'b0 || bif.dvalid !== 4'b0100)
            $display("FAIL bp_end: busy=%b dvalid=%b want 0/0100", bif.busy, bif.dvalid); else pass_cnt++;
        cnt2 = 0;
        foreach (dv_hist[i]) if (dv_hist[i] === 4'b0100) cnt2++;
        total_cnt++; if (cnt2 != 4) $display("FAIL bp_beats: got %0d beats to dst2 want 4", cnt2); else pass_cnt++;
        bad = 0; n = obs_q.size();
        while (exp_q.size() > 0 && obs_q.size() > 0) if (exp_q.pop_front() !== obs_q.pop_front()) bad++;
        total_cnt++; if (bad != 0 || exp_q.size() != 0 || obs_q.size() != 0 || n != 12 || rdy_bad != 0)
            $display("FAIL bp_data: bad=%0d beats=%0d want 12 rdy_bad=%0d", bad, n, rdy_bad);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        int bad, n, cnt1;
        do_reset();
        bif.dst_en = 4'b1111; bif.dst_ready = 4'b1111; bif.din_valid = 1;
        for (int i = 0; i < 8; i++) step();
        total_cnt++; if (bif.sel !== 2'd1 || bif.beat_cnt !== 3'd2)
            $display("FAIL ab_pre: sel=%0d cnt=%0d want 1/2", bif.sel, bif.beat_cnt); else pass_cnt++;
        bif.dst_en = 4'b1101;
        #1;
        total_cnt++; if (bif.din_ready !== 1'b0) $display("FAIL ab_ready: got %b want 0", bif.din_ready); else pass_cnt++;
        step();
        total_cnt++; if (bif.busy !== 1'b0 || bif.beat_cnt !== 3'd0 || bif.dvalid !== 4'b0)
            $display("FAIL ab_idle: busy=%b cnt=%0d dvalid=%b want 0/0/0000", bif.busy, bif.beat_cnt, bif.dvalid); else pass_cnt++;
        step();
        total_cnt++; if (bif.sel !== 2'd2 || bif.busy !== 1'b1)
            $display("FAIL ab_next: sel=%0d busy=%b want 2/1", bif.sel, bif.busy); else pass_cnt++;
        cnt1 = 0;
        foreach (dv_hist[i]) if (dv_hist[i] === 4'b0010) cnt1++;
        total_cnt++; if (cnt1 != 2) $display("FAIL ab_beats: got %0d beats to dst1 want 2", cnt1); else pass_cnt++;
        bad = 0; n = obs_q.size();
        while (exp_q.size() > 0 && obs_q.size() > 0) if (exp_q.pop_front() !== obs_q.pop_front()) bad++;
        total_cnt++; if (bad != 0 || exp_q.size() != 0 || obs_q.size() != 0 || n != 6)
            $display("FAIL ab_data: bad=%0d beats=%0d want 6", bad, n);
        else pass_cnt++;
    endtask

    task automatic test_none_enabled();
        int bad;
        do_reset();
        bif.dst_en = 4'b1111; bif.dst_ready = 4'b1111; bif.din_valid = 1;
        for (int i = 0; i < 6; i++) step();
        bif.dst_en = 4'b0000;
        step();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bif.din_ready !== 1'b0) bad++;
            step();
            if (bif.busy !== 1'b0 || bif.dvalid !== 4'b0 || bif.sel !== 2'd1) bad++;
        end
        total_cnt++; if (bad != 0) $display("FAIL none_idle: %0d bad cycles want 0", bad); else pass_cnt++;
        total_cnt++; if (bif.sel !== 2'd1) $display("FAIL none_sel: got %0d want 1", bif.sel); else pass_cnt++;
        total_cnt++; if (rdy_bad != 0 || exp_q.size() != obs_q.size() || obs_q.size() != 4)
            $display("FAIL none_data: rdy_bad=%0d beats=%0d want 4", rdy_bad, obs_q.size()); else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bif.dst_en = 4'b1111; bif.dst_ready = 4'b1111; bif.din_valid = 1;
        for (int i = 0; i < 18; i++) step();
        total_cnt++; if (bif.sel !== 2'd3 || bif.beat_cnt !== 3'd2 || bif.dvalid !== 4'b1000)
            $display("FAIL mr_pre: sel=%0d cnt=%0d dvalid=%b want 3/2/1000", bif.sel, bif.beat_cnt, bif.dvalid); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++; if ({bif.dout3, bif.dout2, bif.dout1, bif.dout0} !== 4'b0 || bif.dvalid !== 4'b0)
            $display("FAIL mr_out: dout=%b dvalid=%b want 0000/0000",
                     {bif.dout3, bif.dout2, bif.dout1, bif.dout0}, bif.dvalid); else pass_cnt++;
        total_cnt++; if (bif.busy !== 1'b0 || bif.beat_cnt !== 3'd0 || bif.sel !== 2'd0)
            $display("FAIL mr_state: busy=%b cnt=%0d sel=%0d want 0/0/0", bif.busy, bif.beat_cnt, bif.sel); else pass_cnt++;
        #1 rst = 1'b0;
        model_clear();
        step();
        total_cnt++; if (bif.sel !== 2'd0 || bif.busy !== 1'b1)
            $display("FAIL mr_grant: sel=%0d busy=%b want 0/1", bif.sel, bif.busy); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_sparse();
        test_backpressure();
        test_abort();
        test_none_enabled();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
